bcd_to_bin_seq: RTL
===================

Name: bcd_to_bin_seq

Overview:
- Sequential BCD-to-binary converter: the inverse of the team's binary-to-BCD transform.
- Takes a sign bit plus 5 BCD digits (magnitude 0..99999) and produces a 16-bit one's-complement value in the range -32767..+32767.
- Folds in one digit per clock, MSD first, using acc = acc*10 + digit.
- Uses a valid/ready handshake on both input and output. Sits between the keypad/BCD entry path and the binary arithmetic datapath.

Parameters:
N_DIGITS, 5, number of BCD digits accepted (fixed at 5 for this revision)
W_BIN, 16, output width; one's complement; magnitude limit 2^(W_BIN-1)-1 = 32767
W_ACC, 17, accumulator width; must hold 10^N_DIGITS-1 = 99999

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  in  1  input word valid
in_ready  out  1  block can accept a word (high only in IDLE)
sign_in  in  1  1 = negative
bcd_in  in  20  digits; [19:16] = MSD ... [3:0] = LSD
out_valid  out  1  result valid; held until accepted
out_ready  in  1  downstream accepts result
bin_out  out  16  one's-complement result
err_digit  out  1  some nibble of bcd_in was > 9; qualified by out_valid
err_range  out  1  magnitude > 32767; qualified by out_valid

Behaviour:
- Reset (rst_n low at a rising edge):
  - state = IDLE; in_ready = 1; out_valid = 0; bin_out = 16'h0000; err_digit = 0; err_range = 0.
  - Accumulator, digit counter and captured input are cleared.
  - Reset wins over every other event, including an in-flight conversion. No result is produced for an aborted word.
- FSM states: IDLE -> CONV -> SIGN -> DONE -> IDLE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid=1: capture bcd_in and sign_in, set acc = 0, cnt = 4, set the digit-error flag if any nibble > 9, go to CONV.
- CONV:
  - in_ready = 0.
  - Each edge: acc = acc*10 + digit[cnt], where *10 is implemented as (acc<<3)+(acc<<1) at W_ACC width.
  - Decrement cnt. After the edge that consumes digit[0] (5 edges total), go to SIGN.
  - Invalid nibbles are still folded in; the result is discarded later.
- SIGN (one edge), evaluated in priority order:
  1. Digit-error flag set: bin_out = 0, err_digit = 1, err_range = 0.
  2. Otherwise acc > 32767: bin_out = 0, err_range = 1.
  3. Otherwise acc == 0: bin_out = 16'h0000 regardless of sign. Negative zero is never emitted.
  4. Otherwise sign = 0: bin_out = acc[15:0].
  5. Otherwise sign = 1: bin_out = ~acc[15:0].
  - Go to DONE; out_valid = 1.
- DONE:
  - out_valid = 1; bin_out and the err flags are held stable while out_ready = 0.
  - On an edge with out_ready = 1: out_valid = 0, go to IDLE. bin_out keeps its last value; consumers must qualify with out_valid.
- Latency:
  - out_valid rises 6 edges after the accepting edge (5 CONV + 1 SIGN).
  - Throughput: one word per 8 cycles with out_ready tied high. The IDLE bubble is intentional.
- in_valid while busy is ignored; in_ready = 0 is the backpressure. The upstream stage holds its data.
- Boundaries:
  - Magnitude 32767: valid result.
  - Magnitude 32768..99999: err_range.
  - Nibbles A..F: err_digit, which takes priority over err_range.
  - Accumulator cannot overflow at W_ACC = 17.

Decomposition:
- Shared package bcd_pkg holds:
  - state enum {IDLE, CONV, SIGN, DONE};
  - constants N_DIGITS = 5, BCD_W = 4, MAG_MAX = 16'd32767, W_ACC = 17;
  - function is_bcd_digit(nibble).
- The binary-to-BCD transform uses the same package.
- One sub-module: bcd_mac10 (combinational, acc_in[16:0], digit[3:0] -> acc_out[16:0] = acc_in*10 + digit using shifts and add). Reused later by a sequential bin-to-BCD redesign.

Test Plan:
- sign 0, bcd 20'h12345, out_ready 1 -> bin_out 16'h3039, no errors; out_valid exactly 6 edges after accept; in_ready back high 1 cycle after transfer.
- sign 1, bcd 20'h32767 -> bin_out 16'h8000. Then sign 0, bcd 20'h00001 -> 16'h0001.
- sign 0, bcd 20'h32768 -> err_range 1, bin_out 0. Also bcd 20'h1A000 -> err_digit 1, err_range 0, bin_out 0.
- sign 1, bcd 20'h00000 -> bin_out 16'h0000 (not 16'hFFFF).
- out_ready held 0 for 4 cycles after out_valid -> bin_out and flags stable, in_ready 0, new in_valid ignored. Transfer occurs on the first out_ready=1 edge.
- rst_n low for 1 edge during the 3rd CONV cycle -> next cycle IDLE, in_ready 1, out_valid 0, all outputs 0, no result emitted.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit check for the BCD <-> binary converters.
package bcd_pkg;
  localparam int N_DIGITS = 5;
  localparam int BCD_W    = 4;
  localparam int W_BIN    = 16;
  localparam int W_ACC    = 17;
  localparam int CNT_W    = $clog2(N_DIGITS);
  localparam logic [W_BIN-1:0] MAG_MAX = 16'd32767;

  typedef enum logic [1:0] {IDLE, CONV, SIGN, DONE} state_t;

  function automatic logic is_bcd_digit(input logic [BCD_W-1:0] nibble);
    return nibble <= 4'd9;
  endfunction
endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Input word and result handshakes of the BCD-to-binary converter.
interface bcd_to_bin_seq_if;
  import bcd_pkg::*;
  logic                      in_valid;
  logic                      in_ready;
  logic                      sign_in;
  logic [N_DIGITS*BCD_W-1:0] bcd_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [W_BIN-1:0]          bin_out;
  logic                      err_digit;
  logic                      err_range;

  modport master (output in_valid, sign_in, bcd_in, out_ready,
                  input  in_ready, out_valid, bin_out, err_digit, err_range);
  modport slave  (input  in_valid, sign_in, bcd_in, out_ready,
                  output in_ready, out_valid, bin_out, err_digit, err_range);
endinterface

// File: rtl/bcd_mac10.sv
// acc*10 + digit using shifts and adds; shared with the bin-to-BCD datapath.
module bcd_mac10
  import bcd_pkg::*;
(
  input  logic [W_ACC-1:0] i_acc_in,
  input  logic [BCD_W-1:0] i_digit,
  output logic [W_ACC-1:0] o_acc_out
);
  assign o_acc_out = (i_acc_in << 3) + (i_acc_in << 1) + W_ACC'(i_digit);
endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sign + 5 BCD digits to 16-bit one's complement, one digit per clock, MSD first.
module bcd_to_bin_seq
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  bcd_to_bin_seq_if.slave  bus
);
  state_t                          r_state, w_next;
  logic [N_DIGITS-1:0][BCD_W-1:0]  r_bcd;
  logic                            r_sign;
  logic                            r_derr;
  logic [CNT_W-1:0]                r_cnt;
  logic [W_ACC-1:0]                r_acc;
  logic [W_ACC-1:0]                w_acc_nxt;
  logic [W_BIN-1:0]                r_bin;
  logic                            r_err_d;
  logic                            r_err_r;
  logic                            w_derr_in;
  logic                            w_over;
  logic                            w_in_ready;
  logic                            w_out_valid;

  always_comb begin
    w_derr_in = 1'b0;
    for (int i = 0; i < N_DIGITS; i++)
      if (!is_bcd_digit(bus.bcd_in[i*BCD_W +: BCD_W])) w_derr_in = 1'b1;
  end

  bcd_mac10 u_mac10 (
    .i_acc_in  (r_acc),
    .i_digit   (r_bcd[r_cnt]),
    .o_acc_out (w_acc_nxt)
  );

  assign w_over = r_acc > W_ACC'(MAG_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)  w_next = CONV;
      CONV:    if (r_cnt == '0)   w_next = SIGN;
      SIGN:                       w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default:                    w_next = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = (r_state == IDLE);
    w_out_valid = (r_state == DONE);
  end

  // Bad nibbles are folded in like any other; the digit-error flag discards the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bcd   <= '0;
      r_sign  <= 1'b0;
      r_derr  <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_bin   <= '0;
      r_err_d <= 1'b0;
      r_err_r <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_bcd  <= bus.bcd_in;
          r_sign <= bus.sign_in;
          r_derr <= w_derr_in;
          r_acc  <= '0;
          r_cnt  <= CNT_W'(N_DIGITS - 1);
        end
        CONV: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt - 1'b1;
        end
        SIGN: begin
          r_err_d <= r_derr;
          r_err_r <= !r_derr && w_over;
          if (r_derr || w_over || r_acc == '0) r_bin <= '0;
          else if (r_sign)                     r_bin <= ~r_acc[W_BIN-1:0];
          else                                 r_bin <= r_acc[W_BIN-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.bin_out   = r_bin;
  assign bus.err_digit = r_err_d;
  assign bus.err_range = r_err_r;
endmodule
